// File: rtl/jtkunio_pkg.sv
// Shared types and default sizing for the Kunio object-RAM DMA.
package jtkunio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    COPY  = 2'd2,
    FLUSH = 2'd3
  } dma_state_t;

  localparam int OBJ_AW  = 8;
  localparam int OBJ_LEN = 2 ** OBJ_AW;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Only the read register is reset; array contents survive reset.
module jtframe_dual_ram #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= mem[raddr];
  end

endmodule

// File: rtl/jtkunio_objdma.sv
// Object-RAM DMA: copies the CPU sprite table into a private buffer read by the renderer.
// Optional double buffering with swap on LVBL fall: define JTKUNIO_OBJDMA_DBLBUF_EN.
module jtkunio_objdma
  import jtkunio_pkg::*;
#(
  parameter logic [11:0] SRC = 12'h000,
  parameter int          AW  = OBJ_AW
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic          dma_go,
  output logic          busrq,
  input  logic          busak_n,
  output logic [11:0]   dma_addr,
  input  logic [7:0]    dma_din,
  input  logic          LVBL,
  input  logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_dout,
  output logic          dma_busy
);

  localparam logic [AW:0] LAST = (AW+1)'((2 ** AW) - 1);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

`ifdef JTKUNIO_OBJDMA_DBLBUF_EN
  localparam int RAW = AW + 1;
`else
  localparam int RAW = AW;
`endif

  dma_state_t    state_reg;
  logic          pending_reg;
  logic [AW:0]   cnt_reg;
  logic [AW:0]   cnt_dec;
  logic          ram_we;
  logic [AW-1:0] ram_lo;
  logic [RAW-1:0] ram_waddr;
  logic [RAW-1:0] ram_raddr;

  assign cnt_dec = cnt_reg - ONE;

  // Write strobe: the byte for the previous address arrives with the next address issue.
  always_comb begin
    ram_we = 1'b0;
    ram_lo = cnt_dec[AW-1:0];
    if (cen) begin
      case (state_reg)
        COPY:    ram_we = !busak_n && (cnt_reg != '0);
        FLUSH: begin
          ram_we = 1'b1;
          ram_lo = '1;
        end
        default: ram_we = 1'b0;
      endcase
    end
  end

`ifdef JTKUNIO_OBJDMA_DBLBUF_EN
  logic done_reg;
  logic wb_reg;
  logic lvbl_last_reg;

  assign ram_waddr = {wb_reg, ram_lo};
  assign ram_raddr = {~wb_reg, obj_addr};
`else
  logic unused_lvbl;

  assign unused_lvbl = LVBL;
  assign ram_waddr   = ram_lo;
  assign ram_raddr   = obj_addr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pending_reg <= 1'b0;
      cnt_reg     <= '0;
      busrq       <= 1'b0;
      dma_busy    <= 1'b0;
      dma_addr    <= 12'h000;
`ifdef JTKUNIO_OBJDMA_DBLBUF_EN
      done_reg      <= 1'b0;
      wb_reg        <= 1'b1;
      lvbl_last_reg <= 1'b1;
`endif
    end else begin
      // A new trigger always wins over the clear so a request is never lost.
      if (dma_go)
        pending_reg <= 1'b1;
      else if (cen && state_reg == IDLE && pending_reg)
        pending_reg <= 1'b0;

      if (cen) begin
        case (state_reg)
          IDLE: begin
            if (pending_reg) begin
              state_reg <= REQ;
              busrq     <= 1'b1;
              dma_busy  <= 1'b1;
            end
          end
          REQ: begin
            if (!busak_n) begin
              state_reg <= COPY;
              cnt_reg   <= '0;
            end
          end
          COPY: begin
            if (!busak_n) begin
              dma_addr <= SRC + 12'(cnt_reg);
              cnt_reg  <= cnt_reg + ONE;
              if (cnt_reg == LAST) state_reg <= FLUSH;
            end
          end
          FLUSH: begin
            busrq     <= 1'b0;
            dma_busy  <= 1'b0;
            state_reg <= IDLE;
`ifdef JTKUNIO_OBJDMA_DBLBUF_EN
            done_reg  <= 1'b1;
`endif
          end
          default: state_reg <= IDLE;
        endcase
      end

`ifdef JTKUNIO_OBJDMA_DBLBUF_EN
      lvbl_last_reg <= LVBL;
      if (lvbl_last_reg && !LVBL && done_reg) begin
        wb_reg   <= ~wb_reg;
        done_reg <= 1'b0;
      end
`endif
    end
  end

  jtframe_dual_ram #(
    .DW (8),
    .AW (RAW)
  ) u_buf (
    .rst   (rst),
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (dma_din),
    .raddr (ram_raddr),
    .q     (obj_dout)
  );

endmodule

// File: tb/tb_jtkunio_objdma.sv
// Directed bench for jtkunio_objdma; exercises the double-buffer path when
// JTKUNIO_OBJDMA_DBLBUF_EN is defined.
module tb_jtkunio_objdma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic        dma_go = 1'b1;
  logic        busrq;
  logic        busak_n = 1'b1;
  logic [11:0] dma_addr;
  logic [7:0]  dma_din;
  logic        LVBL = 1'b1;
  logic [7:0]  obj_addr = 8'd0;
  logic [7:0]  obj_dout;
  logic        dma_busy;

  int checks = 0;
  int errors = 0;
  int pat = 0;
  int n = 0;
  int stalled = 0;

  always #5 clk = ~clk;

  jtkunio_objdma dut (
    .rst      (rst),
    .clk      (clk),
    .cen      (cen),
    .dma_go   (dma_go),
    .busrq    (busrq),
    .busak_n  (busak_n),
    .dma_addr (dma_addr),
    .dma_din  (dma_din),
    .LVBL     (LVBL),
    .obj_addr (obj_addr),
    .obj_dout (obj_dout),
    .dma_busy (dma_busy)
  );

  // CPU RAM model: content pattern selected by pat, indexed by the low address byte.
  function automatic logic [7:0] pat_fn(input logic [7:0] a, input int p);
    case (p)
      0:       return a ^ 8'h5A;
      1:       return a * 8'd7 + 8'd3;
      2:       return a ^ 8'hC3;
      3:       return ~a;
      4:       return a + 8'd17;
      default: return {a[3:0], a[7:4]};
    endcase
  endfunction

  always_comb dma_din = pat_fn(dma_addr[7:0], pat);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input logic c);
    cen = c;
    @(posedge clk);
    #1;
  endtask

  task automatic cstep();
    cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
  endtask

  task automatic pulse_go();
    dma_go = 1'b1;
    cyc(1'b0);
    dma_go = 1'b0;
  endtask

  // Counts cens seen with busrq high until it drops (bounded).
  task automatic run_out(output int cnt);
    cnt = 0;
    while (busrq === 1'b1 && cnt < 2000) begin
      cstep();
      cnt++;
    end
  endtask

  task automatic wait_addr(input logic [11:0] target);
    int k = 0;
    while (dma_addr !== target && k < 1000) begin
      cstep();
      k++;
    end
    chk($sformatf("wait_addr_%0h", target), 32'(dma_addr), 32'(target));
  endtask

  task automatic readback(input int p, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      obj_addr = 8'(i);
      cyc(1'b0);
      chk($sformatf("rd_p%0d_%0d", p, i), 32'(obj_dout), 32'(pat_fn(8'(i), p)));
    end
  endtask

  task automatic lvbl_fall();
    LVBL = 1'b0;
    cyc(1'b0);
    LVBL = 1'b1;
    cyc(1'b0);
  endtask

  initial begin
    // Reset held with dma_go high
    cyc(1'b0); cyc(1'b0); cstep();
    chk("rst_busrq", 32'(busrq), 32'd0);
    chk("rst_busy", 32'(dma_busy), 32'd0);
    chk("rst_addr", 32'(dma_addr), 32'd0);
    chk("rst_dout", 32'(obj_dout), 32'd0);
    rst = 1'b0;
    cyc(1'b0);
    dma_go = 1'b0;
    cyc(1'b0); cyc(1'b0); cyc(1'b1);
    chk("first_cen_busrq", 32'(busrq), 32'd1);
    chk("first_cen_busy", 32'(dma_busy), 32'd1);

    // Transfer 1, immediate grant; first high cen is the grant-sampling one
    busak_n = 1'b0;
    pat = 0;
    run_out(n);
    chk("t1_hold", 32'(n - 1), 32'd257);
    chk("t1_last_addr", 32'(dma_addr), 32'h0FF);
    chk("t1_busy_end", 32'(dma_busy), 32'd0);

`ifdef JTKUNIO_OBJDMA_DBLBUF_EN
    lvbl_fall();
    readback(0, 0, 255);
    pat = 1;
    pulse_go();
    cstep();
    run_out(n);
    chk("db_t2_hold", 32'(n - 1), 32'd257);
    readback(0, 0, 15);
    lvbl_fall();
    readback(1, 0, 15);
    // Edge during an incomplete transfer must not swap
    pat = 2;
    pulse_go();
    cstep();
    wait_addr(12'h032);
    lvbl_fall();
    readback(1, 0, 15);
    run_out(n);
    readback(1, 0, 15);
    lvbl_fall();
    readback(2, 0, 255);
`else
    readback(0, 0, 255);

    // Grant withdrawn for 10 cens at cnt=100
    pat = 1;
    pulse_go();
    cstep();
    chk("t2_busrq", 32'(busrq), 32'd1);
    n = 0;
    stalled = 0;
    while (busrq === 1'b1 && n < 2000) begin
      cstep();
      n++;
      if (stalled == 0 && dma_addr === 12'h064) begin
        busak_n = 1'b1;
        repeat (10) begin
          cstep();
          n++;
        end
        chk("stall_addr", 32'(dma_addr), 32'h064);
        chk("stall_busrq", 32'(busrq), 32'd1);
        busak_n = 1'b0;
        stalled = 1;
      end
    end
    chk("stall_seen", 32'(stalled), 32'd1);
    chk("t2_hold", 32'(n - 1), 32'd267);
    readback(1, 0, 255);

    // dma_go during a transfer queues exactly one more
    pat = 2;
    pulse_go();
    cstep();
    wait_addr(12'h032);
    pulse_go();
    run_out(n);
    chk("t3_busrq_drop", 32'(busrq), 32'd0);
    pat = 3;
    cstep();
    chk("t3_requeue_busrq", 32'(busrq), 32'd1);
    run_out(n);
    chk("t3b_hold", 32'(n - 1), 32'd257);
    readback(3, 0, 255);

    // Asynchronous reset at cnt=128
    pat = 4;
    pulse_go();
    cstep();
    wait_addr(12'h080);
    cyc(1'b0);
    rst = 1'b1;
    #1;
    chk("arst_busrq", 32'(busrq), 32'd0);
    chk("arst_busy", 32'(dma_busy), 32'd0);
    chk("arst_addr", 32'(dma_addr), 32'd0);
    chk("arst_dout", 32'(obj_dout), 32'd0);
    cyc(1'b0);
    rst = 1'b0;
    cstep(); cstep(); cstep();
    chk("arst_idle_busrq", 32'(busrq), 32'd0);
    readback(4, 0, 127);
    readback(3, 128, 255);

    // dma_go coincident with cen: REQ only on the following cen
    pat = 5;
    dma_go = 1'b1;
    cyc(1'b1);
    dma_go = 1'b0;
    chk("go_cen_busrq0", 32'(busrq), 32'd0);
    cstep();
    chk("go_cen_busrq1", 32'(busrq), 32'd1);
    run_out(n);
    chk("t5_hold", 32'(n - 1), 32'd257);
    readback(5, 0, 7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtkunio_objdma.md
# jtkunio_objdma

Object-RAM DMA engine sitting between the main CPU bus and the object (sprite) renderer inside the video stage. When the CPU writes the DMA trigger (`dma_go`), the block requests the bus, waits for the CPU to grant it, copies the sprite attribute table from CPU RAM into a private object buffer, then releases the bus. The renderer reads that buffer through a dedicated read port at pixel rate.

## Interface
Parameters:
- `SRC`, 12'h000 — CPU-space base address of the sprite table.
- `AW`, 8 — buffer address width; transfer length `LEN = 2**AW` bytes.

Ports:
- `rst`  in  1  reset; asynchronous, active-high.
- `clk`  in  1  system clock; the only clock.
- `cen`  in  1  pixel clock enable (6 MHz); all DMA steps advance only on `cen`.
- `dma_go`  in  1  trigger pulse from CPU decoder; may arrive on any `clk`.
- `busrq`  out  1  bus request, active-high.
- `busak_n`  in  1  bus acknowledge, active-low.
- `dma_addr`  out  12  source address driven onto the CPU bus.
- `dma_din`  in  8  CPU RAM read data, valid one `cen` after `dma_addr`.
- `LVBL`  in  1  vertical blank, active-low.
- `obj_addr`  in  AW  renderer read address.
- `obj_dout`  out  8  renderer read data.
- `dma_busy`  out  1  high from request until bus release.

## Operation
- `dma_go` sets a `pending` flag on any `clk`. The flag is cleared when `REQ` is entered. At most one request is queued: a `dma_go` during a transfer runs once more after the current transfer ends.
- FSM states, each advancing only on `cen`:
  - `IDLE`: if `pending` is set, go to `REQ` and set `busrq=1`, `dma_busy=1`.
  - `REQ`: when `busak_n=0` is sampled, go to `COPY` with `cnt=0`.
  - `COPY`: each `cen` with `busak_n=0`:
    - `dma_addr = SRC + cnt`, 12-bit and wrapping.
    - If `cnt>0`, write `buf[cnt-1] = dma_din`.
    - Increment `cnt`.
    - After the address for `cnt=LEN-1` has been issued, go to `FLUSH`.
  - `COPY` with `busak_n=1` (grant withdrawn): stall. `cnt`, `dma_addr` and the pipeline hold, and `busrq` stays high.
  - `FLUSH`: write `buf[LEN-1] = dma_din`, set `busrq=0` and `dma_busy=0`, set `done`, go to `IDLE`.
- `cnt` is AW+1 bits wide, so `LEN` is reachable without wrap.
- `obj_dout` is registered: it shows `buf[obj_addr]` one `clk` after `obj_addr` changes, independent of `cen`.

## Timing
- Reset values: `busrq=0`, `dma_busy=0`, `dma_addr=0`, `obj_dout=0`, state `IDLE`, `pending=0`, `done=0`, read bank 0. Buffer contents are not reset.
- Reset asserted mid-transfer: outputs return to reset values immediately, so `busrq` drops asynchronously. Partially written buffer contents remain.
- Latency, with immediate grant: `dma_go` → `busrq` on the next `cen`. The grant is seen one `cen` later. Total bus hold is `LEN+1` cens, plus any stall cens.
- `dma_go` and `cen` in the same `clk`: `pending` is set, and `REQ` is entered on the following `cen`.
- `dma_go` in the same `cen` as `FLUSH`: it is queued, and `REQ` follows after one `IDLE` cen.

## Configuration
- `JTKUNIO_OBJDMA_DBLBUF_EN` defined:
  - Two `LEN`-byte banks. DMA writes bank `wb` and the renderer reads bank `~wb`.
  - On a `LVBL` falling edge, if `done` is set, toggle `wb` and clear `done`.
  - A transfer still in progress at the `LVBL` edge does not swap.
- Macro undefined: single bank. DMA writes and the renderer reads the same bank, so tearing is allowed and `done` is unused.

## Structure
- Package `jtkunio_pkg`: FSM state enum (`IDLE`, `REQ`, `COPY`, `FLUSH`) and the default `AW` / `LEN` constants.
- Buffer: one `jtframe_dual_ram` instance.
  - Write port driven by the DMA.
  - Read port driven by `obj_addr`.
  - Depth `LEN` or `2*LEN` depending on `JTKUNIO_OBJDMA_DBLBUF_EN`; the bank bit is the address MSB.

## Test plan
- Reset with `dma_go` held high → all outputs 0 after reset. After release, `busrq=1` on the first `cen`.
- RAM[i]=i^8'h5A with `SRC=12'h000` and immediate grant → `busrq` high for 257 cens, and reading `obj_addr` 0..255 returns i^8'h5A.
- `busak_n` deasserted for 10 cens at `cnt=100` → `dma_addr` holds 12'h064, no bytes are lost or duplicated, and bus hold is 267 cens.
- `dma_go` pulsed at `cnt=50` → a second full transfer starts with `busrq` re-raised after one `IDLE` cen.
- `JTKUNIO_OBJDMA_DBLBUF_EN`, transfer completes before a `LVBL` fall → the renderer sees the new data only after the edge. If the transfer is incomplete at the edge, the renderer keeps the old data.
- Reset pulsed at `cnt=128` → `busrq` drops in the same `clk` and the FSM is in `IDLE`.
